// File: rtl/sprite_compositor.sv
// Sprite compositor: per-layer bounds test, ROM addressing and priority/opacity
// merge in a fixed-latency pipeline of 2 + ROM_LAT + 1 cycles.
module sprite_compositor #(
    parameter int          NUM_LAYERS = 4,
    parameter int          COORD_W    = 11,
    parameter int          SPR_W      = 180,
    parameter int          SPR_H      = 180,
    parameter int          FRAMES     = 6,
    parameter int          ROM_LAT    = 1,
    parameter int          MASK_THR   = 5,
    parameter logic [11:0] BG_COLOR   = 12'hFFF,
    localparam int         ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_frame_start,
    input  logic [NUM_LAYERS*COORD_W-1:0] i_spr_x,
    input  logic [NUM_LAYERS*COORD_W-1:0] i_spr_y,
    input  logic [NUM_LAYERS-1:0]         i_spr_en,
    input  logic [NUM_LAYERS*4-1:0]       i_spr_frame,
    input  logic                          i_valid,
    input  logic [COORD_W-1:0]            i_x_read,
    input  logic [COORD_W-1:0]            i_y_read,
    output logic [NUM_LAYERS*ADDR_W-1:0]  o_rom_addr,
    input  logic [NUM_LAYERS*12-1:0]      i_rom_rgb,
    input  logic [NUM_LAYERS*4-1:0]       i_rom_mask,
    output logic                          o_valid,
    output logic [11:0]                   o_rgb,
    output logic [NUM_LAYERS-1:0]         o_hit
);

    // Valid-only stream: a request is taken every cycle i_valid=1 (no backpressure);
    // o_valid is i_valid delayed by the fixed pipeline latency, bubbles preserved.

    localparam logic signed [COORD_W:0] SPR_W_S   = (COORD_W+1)'(SPR_W);
    localparam logic signed [COORD_W:0] SPR_H_S   = (COORD_W+1)'(SPR_H);
    localparam logic [4:0]              FRAMES_C  = 5'(FRAMES);
    localparam logic [ADDR_W-1:0]       FRAME_PIX = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0]       ROW_PIX   = ADDR_W'(SPR_W);
    localparam logic [3:0]              THR_C     = 4'(MASK_THR);

    logic [COORD_W-1:0]        sh_x     [NUM_LAYERS];
    logic [COORD_W-1:0]        sh_y     [NUM_LAYERS];
    logic [3:0]                sh_frame [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]     sh_en;

    logic signed [COORD_W:0]   rx_c     [NUM_LAYERS];
    logic signed [COORD_W:0]   ry_c     [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]     act_c;

    logic [COORD_W-1:0]        s1_rx    [NUM_LAYERS];
    logic [COORD_W-1:0]        s1_ry    [NUM_LAYERS];
    logic [3:0]                s1_frame [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]     s1_act;
    logic                      s1_valid;

    logic [ADDR_W-1:0]         addr_c   [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]     s2_act;
    logic                      s2_valid;

    logic [NUM_LAYERS-1:0]     dly_act  [ROM_LAT];
    logic [ROM_LAT-1:0]        dly_valid;

    logic [11:0]               pix_c;
    logic [NUM_LAYERS-1:0]     hit_c;

    // Requests in the same cycle as i_frame_start still see the old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en <= '0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                sh_x[k]     <= '0;
                sh_y[k]     <= '0;
                sh_frame[k] <= '0;
            end
        end else if (i_frame_start) begin
            sh_en <= i_spr_en;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                sh_x[k]     <= i_spr_x[k*COORD_W +: COORD_W];
                sh_y[k]     <= i_spr_y[k*COORD_W +: COORD_W];
                sh_frame[k] <= i_spr_frame[k*4 +: 4];
            end
        end
    end

    // Extra sign bit keeps pixels left of / above the sprite negative.
    always_comb begin
        act_c = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            rx_c[k]  = $signed({1'b0, i_x_read}) - $signed({1'b0, sh_x[k]});
            ry_c[k]  = $signed({1'b0, i_y_read}) - $signed({1'b0, sh_y[k]});
            act_c[k] = sh_en[k] && ({1'b0, sh_frame[k]} < FRAMES_C)
                    && !rx_c[k][COORD_W] && (rx_c[k] < SPR_W_S)
                    && !ry_c[k][COORD_W] && (ry_c[k] < SPR_H_S);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_act   <= '0;
            s1_valid <= 1'b0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s1_rx[k]    <= '0;
                s1_ry[k]    <= '0;
                s1_frame[k] <= '0;
            end
        end else begin
            s1_act   <= act_c;
            s1_valid <= i_valid;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s1_rx[k]    <= rx_c[k][COORD_W-1:0];
                s1_ry[k]    <= ry_c[k][COORD_W-1:0];
                s1_frame[k] <= sh_frame[k];
            end
        end
    end

    // All terms are evaluated at ADDR_W, which holds the largest legal address.
    always_comb begin
        for (int k = 0; k < NUM_LAYERS; k++) begin
            addr_c[k] = '0;
            if (s1_act[k]) begin
                addr_c[k] = ADDR_W'(s1_frame[k]) * FRAME_PIX
                          + ADDR_W'(s1_ry[k]) * ROW_PIX
                          + ADDR_W'(s1_rx[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rom_addr <= '0;
            s2_act     <= '0;
            s2_valid   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                o_rom_addr[k*ADDR_W +: ADDR_W] <= addr_c[k];
            end
            s2_act   <= s1_act;
            s2_valid <= s1_valid;
        end
    end

    // Active flags and valid ride alongside the external ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_valid <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                dly_act[i] <= '0;
            end
        end else begin
            dly_act[0]   <= s2_act;
            dly_valid[0] <= s2_valid;
            for (int i = 1; i < ROM_LAT; i++) begin
                dly_act[i]   <= dly_act[i-1];
                dly_valid[i] <= dly_valid[i-1];
            end
        end
    end

    // Ascending scan: the last qualifying layer (highest index) wins.
    always_comb begin
        pix_c = BG_COLOR;
        hit_c = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            hit_c[k] = dly_act[ROM_LAT-1][k] && (i_rom_mask[k*4 +: 4] > THR_C);
            if (hit_c[k]) begin
                pix_c = i_rom_rgb[k*12 +: 12];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_rgb   <= '0;
            o_hit   <= '0;
        end else begin
            o_valid <= dly_valid[ROM_LAT-1];
            if (dly_valid[ROM_LAT-1]) begin
                o_rgb <= pix_c;
                o_hit <= hit_c;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: two instances (ROM_LAT=1 and 3) fed identically and
// checked every cycle against a cycle-indexed reference model of the compositing rules.
module tb_sprite_compositor;

    localparam int NL = 4;
    localparam int CW = 11;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, frame_start, req_valid;
    logic [NL*CW-1:0] spr_x, spr_y;
    logic [NL-1:0]    spr_en;
    logic [NL*4-1:0]  spr_frame;
    logic [CW-1:0]    x_read, y_read;

    logic [NL*AW-1:0] addr_a, addr_b;
    logic [NL*12-1:0] rom_rgb_a, rom_rgb_b, b_rgb1, b_rgb2;
    logic [NL*4-1:0]  rom_mask_a, rom_mask_b, b_mask1, b_mask2;
    logic             ov_a, ov_b;
    logic [11:0]      rgb_a, rgb_b;
    logic [NL-1:0]    hit_a, hit_b;

    sprite_compositor #(.ROM_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start),
        .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en), .i_spr_frame(spr_frame),
        .i_valid(req_valid), .i_x_read(x_read), .i_y_read(y_read),
        .o_rom_addr(addr_a), .i_rom_rgb(rom_rgb_a), .i_rom_mask(rom_mask_a),
        .o_valid(ov_a), .o_rgb(rgb_a), .o_hit(hit_a)
    );

    sprite_compositor #(.ROM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start),
        .i_spr_x(spr_x), .i_spr_y(spr_y), .i_spr_en(spr_en), .i_spr_frame(spr_frame),
        .i_valid(req_valid), .i_x_read(x_read), .i_y_read(y_read),
        .o_rom_addr(addr_b), .i_rom_rgb(rom_rgb_b), .i_rom_mask(rom_mask_b),
        .o_valid(ov_b), .o_rgb(rgb_b), .o_hit(hit_b)
    );

    // ROM contents: colour and mask are fixed hashes of (layer, address);
    // the mask of a layer can be pinned to a constant for directed cases.
    bit       force_en   [NL];
    bit [3:0] force_mask [NL];

    function automatic logic [11:0] rom_rgb(input int k, input int addr);
        return 12'((addr * 7 + k * 1301 + 5) ^ (addr >> 5));
    endfunction

    function automatic logic [3:0] rom_mask(input int k, input int addr);
        if (force_en[k]) return force_mask[k];
        return 4'((addr >> 1) ^ (addr * 3) ^ k);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            rom_rgb_a[k*12 +: 12] <= rom_rgb(k, int'(addr_a[k*AW +: AW]));
            rom_mask_a[k*4 +: 4]  <= rom_mask(k, int'(addr_a[k*AW +: AW]));
            b_rgb1[k*12 +: 12]    <= rom_rgb(k, int'(addr_b[k*AW +: AW]));
            b_mask1[k*4 +: 4]     <= rom_mask(k, int'(addr_b[k*AW +: AW]));
        end
        b_rgb2     <= b_rgb1;
        b_mask2    <= b_mask1;
        rom_rgb_b  <= b_rgb2;
        rom_mask_b <= b_mask2;
    end

    // Reference model state and cycle-indexed expectations (ring of 16 cycles).
    int          cyc;
    int          m_x [NL], m_y [NL], m_frame [NL];
    bit          m_en [NL];
    bit          exp_v   [2][16];
    logic [11:0] exp_rgb [2][16];
    logic [3:0]  exp_hit [2][16];
    bit          exp_av  [16];
    int          exp_addr[16][NL];
    logic [11:0] last_rgb [2];
    logic [3:0]  last_hit [2];

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int          rx, ry, addr;
        bit          act;
        logic [11:0] rgb;
        logic [3:0]  hit;
        int          n1;
        cyc++;
        if (!rst_n) begin
            for (int s = 0; s < 16; s++) begin
                exp_av[s] = 0;
                for (int d = 0; d < 2; d++) exp_v[d][s] = 0;
            end
            for (int d = 0; d < 2; d++) begin
                last_rgb[d] = '0;
                last_hit[d] = '0;
            end
            for (int k = 0; k < NL; k++) begin
                m_x[k] = 0; m_y[k] = 0; m_frame[k] = 0; m_en[k] = 0;
            end
            return;
        end
        n1 = (cyc + 1) % 16;
        rgb = 12'hFFF;
        hit = '0;
        exp_av[n1] = req_valid;
        for (int k = 0; k < NL; k++) begin
            rx   = int'(x_read) - m_x[k];
            ry   = int'(y_read) - m_y[k];
            act  = m_en[k] && m_frame[k] < 6 && rx >= 0 && rx < 180 && ry >= 0 && ry < 180;
            addr = act ? m_frame[k] * 32400 + ry * 180 + rx : 0;
            exp_addr[n1][k] = addr;
            if (act && rom_mask(k, addr) > 4'd5) begin
                hit[k] = 1'b1;
                rgb    = rom_rgb(k, addr);
            end
        end
        for (int d = 0; d < 2; d++) begin
            int s;
            s = (cyc + (d == 0 ? 3 : 5)) % 16;
            exp_v[d][s]   = req_valid;
            exp_rgb[d][s] = rgb;
            exp_hit[d][s] = hit;
        end
        if (frame_start) begin
            for (int k = 0; k < NL; k++) begin
                m_x[k]     = int'(spr_x[k*CW +: CW]);
                m_y[k]     = int'(spr_y[k*CW +: CW]);
                m_frame[k] = int'(spr_frame[k*4 +: 4]);
                m_en[k]    = spr_en[k];
            end
        end
    endtask

    task automatic check_outputs();
        int          s;
        logic        ov;
        logic [11:0] rg;
        logic [3:0]  ht;
        s = cyc % 16;
        for (int d = 0; d < 2; d++) begin
            ov = (d == 0) ? ov_a : ov_b;
            rg = (d == 0) ? rgb_a : rgb_b;
            ht = (d == 0) ? hit_a : hit_b;
            chk($sformatf("o_valid[%0d] cyc %0d", d, cyc), 32'(ov), 32'(exp_v[d][s]));
            if (exp_v[d][s]) begin
                chk($sformatf("o_rgb[%0d] cyc %0d", d, cyc), 32'(rg), 32'(exp_rgb[d][s]));
                chk($sformatf("o_hit[%0d] cyc %0d", d, cyc), 32'(ht), 32'(exp_hit[d][s]));
                last_rgb[d] = exp_rgb[d][s];
                last_hit[d] = exp_hit[d][s];
            end else begin
                chk($sformatf("hold_rgb[%0d] cyc %0d", d, cyc), 32'(rg), 32'(last_rgb[d]));
                chk($sformatf("hold_hit[%0d] cyc %0d", d, cyc), 32'(ht), 32'(last_hit[d]));
            end
        end
        if (exp_av[s]) begin
            for (int k = 0; k < NL; k++) begin
                chk($sformatf("addr_a l%0d cyc %0d", k, cyc), 32'(addr_a[k*AW +: AW]), 32'(exp_addr[s][k]));
                chk($sformatf("addr_b l%0d cyc %0d", k, cyc), 32'(addr_b[k*AW +: AW]), 32'(exp_addr[s][k]));
            end
        end
    endtask

    task automatic step(input bit v, input int x, input int y, input bit fs);
        req_valid   = v;
        x_read      = CW'(x);
        y_read      = CW'(y);
        frame_start = fs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        req_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic set_layer(input int k, input int x, input int y, input int en, input int fr);
        spr_x[k*CW +: CW]   = CW'(x);
        spr_y[k*CW +: CW]   = CW'(y);
        spr_en[k]           = en[0];
        spr_frame[k*4 +: 4] = 4'(fr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ov_a"}, 32'(ov_a), 32'd0);
        chk({tag, " ov_b"}, 32'(ov_b), 32'd0);
        chk({tag, " rgb_a"}, 32'(rgb_a), 32'd0);
        chk({tag, " hit_b"}, 32'(hit_b), 32'd0);
        chk({tag, " addr_a0"}, 32'(addr_a[AW-1:0]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst_n = 1'b0; frame_start = 1'b0; req_valid = 1'b0;
        x_read = '0; y_read = '0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_frame = '0;
        for (int k = 0; k < NL; k++) begin
            force_en[k] = 0; force_mask[k] = 4'h0;
        end

        idle(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Layer 0 would cover (10,10) but no frame_start has been seen yet.
        force_en[0] = 1; force_mask[0] = 4'hF;
        set_layer(0, 0, 0, 1, 0);
        step(1'b1, 10, 10, 1'b0);
        idle(3);
        chk("first_px valid", 32'(ov_a), 32'd1);
        chk("first_px rgb", 32'(rgb_a), 32'hFFF);
        chk("first_px hit", 32'(hit_a), 32'd0);
        idle(4);

        // Layer 0 at (100,50), frame 2: corners and just-outside pixels.
        set_layer(0, 100, 50, 1, 2);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 100, 50, 1'b0);
        idle(1);
        chk("addr top-left", 32'(addr_a[AW-1:0]), 32'd64800);
        step(1'b1, 279, 229, 1'b0);
        idle(1);
        chk("addr bottom-right", 32'(addr_a[AW-1:0]), 32'd97199);
        step(1'b1, 99, 50, 1'b0);
        idle(1);
        chk("addr left-outside", 32'(addr_a[AW-1:0]), 32'd0);
        step(1'b1, 280, 50, 1'b0);
        idle(1);
        chk("addr right-outside", 32'(addr_a[AW-1:0]), 32'd0);
        idle(6);

        // Layers 0 and 2 overlapping at (200,100).
        force_en[2] = 1; force_mask[2] = 4'hF;
        set_layer(2, 150, 80, 1, 1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 200, 100, 1'b0);
        idle(7);
        chk("overlap rgb_a", 32'(rgb_a), 32'(rom_rgb(2, 36050)));
        chk("overlap rgb_b", 32'(rgb_b), 32'(rom_rgb(2, 36050)));
        chk("overlap hit_a", 32'(hit_a), 32'b0101);
        force_mask[2] = 4'h5;
        idle(2);
        step(1'b1, 200, 100, 1'b0);
        idle(7);
        chk("thr rgb_a", 32'(rgb_a), 32'(rom_rgb(0, 73900)));
        chk("thr hit_b", 32'(hit_b), 32'b0001);

        // Frame index equal to FRAMES disables the layer.
        set_layer(0, 100, 50, 1, 6);
        step(1'b0, 0, 0, 1'b1);
        step(1'b1, 200, 100, 1'b0);
        idle(7);
        chk("bad frame hit_a", 32'(hit_a), 32'd0);
        chk("bad frame rgb_b", 32'(rgb_b), 32'hFFF);

        // Shadow load coinciding with a request.
        set_layer(0, 100, 50, 1, 2);
        step(1'b0, 0, 0, 1'b1);
        set_layer(0, 101, 50, 1, 2);
        step(1'b1, 100, 50, 1'b1);
        step(1'b1, 100, 50, 1'b0);
        chk("old x addr", 32'(addr_a[AW-1:0]), 32'd64800);
        idle(1);
        chk("new x addr", 32'(addr_a[AW-1:0]), 32'd0);
        idle(6);

        // Gapped stream with an asynchronous reset in the middle.
        for (int i = 0; i < 12; i++) step(i % 2 == 0, 140 + i * 3, 90 + i, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        idle(2);
        rst_n = 1'b1;
        set_layer(1, 120, 70, 1, 3);
        step(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 14; i++) step(i % 2 == 0, 125 + i * 5, 75 + i * 2, 1'b0);
        idle(8);

        // Randomised configurations and requests with hashed masks.
        for (int k = 0; k < NL; k++) force_en[k] = 0;
        for (int i = 0; i < 400; i++) begin
            bit fs;
            fs = (i % 40 == 0) || ($urandom_range(0, 63) == 0);
            if (fs) begin
                for (int k = 0; k < NL; k++) begin
                    set_layer(k, $urandom_range(0, 450), $urandom_range(0, 450),
                              int'($urandom_range(0, 3) != 0), $urandom_range(0, 7));
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 640), $urandom_range(0, 640), fs);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
